// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag/abort detection, zero-deletion and LSB-first octet
// assembly, with a 7-bit delay line hiding flag/abort leading bits from the assembler.
module hdlc_rx_deframer #(
   parameter int MAXLEN = 126
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       rxen,
   input  logic       rx,
   output logic [7:0] rxd_o,
   output logic       rxd_valid_o,
   output logic       frame_start_o,
   output logic       frame_end_o,
   output logic       frame_err_o,
   output logic       abort_o,
   output logic       flagdetect_o,
   output logic       frame_active_o
);

   typedef enum logic [1:0] {HUNT, FLAG, DATA} state_t;

   localparam logic [8:0] MAX_BYTES = 9'(MAXLEN);

   state_t     state;
   logic [2:0] ones;
   logic [6:0] dly;
   logic [2:0] dly_cnt;
   logic [7:0] asm_byte;
   logic [2:0] bit_cnt;
   logic [8:0] byte_cnt;

   logic push, flag_ev, abort_ev, exit_vld;

   // Classification uses the run length of ones seen before this bit.
   always_comb begin
      push     = 1'b0;
      flag_ev  = 1'b0;
      abort_ev = 1'b0;
      if (rxen) begin
         case (ones)
            3'd5:    push = rx;
            3'd6:    begin flag_ev = ~rx; abort_ev = rx; end
            3'd7:    ;
            default: push = 1'b1;
         endcase
      end
   end

   assign exit_vld = push && (state != HUNT) && (dly_cnt == 3'd7);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state          <= HUNT;
         ones           <= 3'd0;
         dly            <= 7'd0;
         dly_cnt        <= 3'd0;
         asm_byte       <= 8'h00;
         bit_cnt        <= 3'd0;
         byte_cnt       <= 9'd0;
         rxd_o          <= 8'h00;
         rxd_valid_o    <= 1'b0;
         frame_start_o  <= 1'b0;
         frame_end_o    <= 1'b0;
         frame_err_o    <= 1'b0;
         abort_o        <= 1'b0;
         flagdetect_o   <= 1'b0;
         frame_active_o <= 1'b0;
      end else begin
         rxd_valid_o   <= 1'b0;
         frame_start_o <= 1'b0;
         frame_end_o   <= 1'b0;
         frame_err_o   <= 1'b0;
         abort_o       <= 1'b0;
         flagdetect_o  <= 1'b0;
         if (rxen) begin
            ones <= rx ? ((ones == 3'd7) ? 3'd7 : ones + 3'd1) : 3'd0;
            if (flag_ev) begin
               flagdetect_o <= 1'b1;
               if (state == DATA) begin
                  frame_end_o <= 1'b1;
                  frame_err_o <= (bit_cnt != 3'd0);
               end
               state          <= FLAG;
               frame_active_o <= 1'b0;
               dly_cnt        <= 3'd0;
               bit_cnt        <= 3'd0;
               byte_cnt       <= 9'd0;
            end else if (abort_ev) begin
               if (state == DATA) abort_o <= 1'b1;
               state          <= HUNT;
               frame_active_o <= 1'b0;
               dly_cnt        <= 3'd0;
               bit_cnt        <= 3'd0;
               byte_cnt       <= 9'd0;
            end else if (push && state != HUNT) begin
               dly <= {rx, dly[6:1]};
               if (dly_cnt != 3'd7) dly_cnt <= dly_cnt + 3'd1;
               if (exit_vld) begin
                  if (state == FLAG) begin
                     state          <= DATA;
                     frame_active_o <= 1'b1;
                     frame_start_o  <= 1'b1;
                  end
                  asm_byte[bit_cnt] <= dly[0];
                  bit_cnt           <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (byte_cnt + 9'd1 <= MAX_BYTES) begin
                        byte_cnt    <= byte_cnt + 9'd1;
                        rxd_o       <= {dly[0], asm_byte[6:0]};
                        rxd_valid_o <= 1'b1;
                     end else begin
                        // Overlong: close with error and drop everything up to the next flag.
                        frame_end_o    <= 1'b1;
                        frame_err_o    <= 1'b1;
                        state          <= HUNT;
                        frame_active_o <= 1'b0;
                        dly_cnt        <= 3'd0;
                        byte_cnt       <= 9'd0;
                     end
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Bench for hdlc_rx_deframer: directed and random frames, each reduced by a
// frame-level model to an ordered list of expected output pulse words.
module tb_hdlc_rx_deframer;
   localparam int MAXLEN = 4;

   logic       clk_i = 1'b0;
   logic       rst_n_i = 1'b0;
   logic       rxen = 1'b0;
   logic       rx = 1'b0;
   logic [7:0] rxd_o;
   logic       rxd_valid_o, frame_start_o, frame_end_o, frame_err_o;
   logic       abort_o, flagdetect_o, frame_active_o;

   hdlc_rx_deframer #(.MAXLEN(MAXLEN)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .rxen(rxen), .rx(rx),
      .rxd_o(rxd_o), .rxd_valid_o(rxd_valid_o), .frame_start_o(frame_start_o),
      .frame_end_o(frame_end_o), .frame_err_o(frame_err_o), .abort_o(abort_o),
      .flagdetect_o(flagdetect_o), .frame_active_o(frame_active_o)
   );

   always #5 clk_i = ~clk_i;

   localparam logic [13:0] FD = 14'h2000, ST = 14'h1000, VL = 14'h0800;
   localparam logic [13:0] EN = 14'h0400, ER = 14'h0200, AB = 14'h0100;

   int          checks = 0;
   int          errors = 0;
   logic [13:0] exp_q[$];
   bit          pay[$];
   bit          line[$];

   function automatic logic [13:0] obs_word();
      return {flagdetect_o, frame_start_o, rxd_valid_o, frame_end_o, frame_err_o, abort_o,
              rxd_valid_o ? rxd_o : 8'h00};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: drive after the edge, observe on the falling edge.
   task automatic tick(input logic en, input logic b);
      logic        strobed;
      logic [13:0] w, e;
      @(posedge clk_i); #1;
      strobed = rxen;
      rxen = en;
      rx   = b;
      @(negedge clk_i);
      w = obs_word();
      if (w != 14'h0) begin
         check("pulse_after_strobe", 32'(strobed), 32'd1);
         e = 14'h3fff;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         check("event", 32'(w), 32'(e));
      end
   endtask

   task automatic send_bit(input logic b);
      tick(1'b1, b);
      repeat (3) tick(1'b0, 1'b0);
   endtask

   task automatic send_flag();
      logic [7:0] fp;
      fp = 8'h7E;
      for (int i = 0; i < 8; i++) send_bit(fp[i]);
   endtask

   task automatic send_raw_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
   endtask

   task automatic push_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) pay.push_back(v[i]);
   endtask

   task automatic settle(input string tag);
      repeat (6) tick(1'b0, 1'b0);
      check({tag, "_active"}, 32'(frame_active_o), 32'd0);
      check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Frame-level model: an abort's seven ones swallow the last payload bit and
   // any trailing ones that precede it; a closing flag lets every payload bit out.
   task automatic run_frame(input string tag, input bit abort_end);
      int          n, k, e, nb, run;
      logic [7:0]  by;
      logic [13:0] w;
      line.delete();
      run = 0;
      foreach (pay[i]) begin
         line.push_back(pay[i]);
         if (pay[i]) run++; else run = 0;
         if (run == 5) begin line.push_back(1'b0); run = 0; end
      end
      k = 0;
      for (int i = line.size() - 1; i >= 0 && line[i]; i--) k++;
      n = pay.size();
      e = abort_end ? n - 1 - k : n;
      if (e < 0) e = 0;
      nb = e / 8;
      exp_q.push_back(FD);
      if (e > 0) exp_q.push_back(ST);
      for (int i = 0; i < nb && i < MAXLEN; i++) begin
         for (int j = 0; j < 8; j++) by[j] = pay[8*i + j];
         exp_q.push_back(VL | 14'(by));
      end
      if (nb > MAXLEN) exp_q.push_back(EN | ER);
      if (!abort_end) begin
         if (nb > MAXLEN || e == 0) w = FD;
         else w = FD | EN | (((e % 8) != 0) ? ER : 14'h0);
         exp_q.push_back(w);
      end else if (nb <= MAXLEN && e > 0) begin
         exp_q.push_back(AB);
      end
      send_flag();
      foreach (line[i]) send_bit(line[i]);
      if (abort_end) repeat (7) send_bit(1'b1);
      else send_flag();
      settle(tag);
      pay.delete();
   endtask

   initial begin
      repeat (3) tick(1'b0, 1'b0);
      check("reset_outputs", 32'({obs_word(), rxd_o, frame_active_o}), 32'd0);
      @(posedge clk_i); #1 rst_n_i = 1'b1;
      repeat (2) tick(1'b0, 1'b0);

      push_byte(8'hA5);
      run_frame("a5", 1'b0);

      push_byte(8'hFF);
      run_frame("ff_stuffed", 1'b0);

      // The extra zero lets 0x12 clear the delay line before the abort.
      push_byte(8'h12);
      pay.push_back(1'b0);
      run_frame("abort", 1'b1);
      send_raw_byte(8'h34);
      settle("hunt_after_abort");

      push_byte(8'h5A);
      pay.push_back(1'b1); pay.push_back(1'b0); pay.push_back(1'b0); pay.push_back(1'b1);
      run_frame("partial", 1'b0);

      for (int i = 1; i <= 5; i++) push_byte(8'(i));
      run_frame("overlong", 1'b0);

      repeat (3) exp_q.push_back(FD);
      repeat (3) send_flag();
      repeat (20) send_bit(1'b1);
      settle("flags_idle");

      exp_q.push_back(FD);
      exp_q.push_back(ST);
      send_flag();
      repeat (10) send_bit(1'b0);
      check("midframe_active", 32'(frame_active_o), 32'd1);
      check("midframe_drained", 32'(exp_q.size()), 32'd0);
      @(posedge clk_i); #1 rst_n_i = 1'b0;
      #1;
      check("async_reset_outputs", 32'({obs_word(), rxd_o, frame_active_o}), 32'd0);
      repeat (3) tick(1'b0, 1'b0);
      @(posedge clk_i); #1 rst_n_i = 1'b1;
      send_raw_byte(8'hA5);
      settle("hunt_after_reset");
      push_byte(8'h3C);
      run_frame("after_reset", 1'b0);

      for (int f = 0; f < 40; f++) begin
         int len;
         len = $urandom_range(0, 44);
         for (int i = 0; i < len; i++) pay.push_back($urandom_range(0, 3) != 0);
         run_frame("random", $urandom_range(0, 3) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
